// File: rtl/ex3_sched_pkg.sv
// Shared types and widths for the Exercise3 datapath scheduler.
package ex3_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

  localparam int SEL_W = 4;
  localparam int OPD_W = 16;
  localparam int RES_W = 16;

endpackage

// File: rtl/ex3_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps;
// the pointer only moves when the caller reports an accepted grant via advance.
module ex3_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    cand      = ptr;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer starts at the last index so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/ex3_scheduler.sv
// Round-robin front end for the shared Exercise3 datapath with credit-protected
// response FIFO and drain/flush FSM. Statistics counters built only with EX3_SCHED_STATS_EN.
module ex3_scheduler
  import ex3_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*SEL_W-1:0] req_a,
  input  logic [NUM_REQ*OPD_W-1:0] req_b,
  input  logic [NUM_REQ*OPD_W-1:0] req_c,
  output logic [SEL_W-1:0]         dp_a,
  output logic [OPD_W-1:0]         dp_b,
  output logic [OPD_W-1:0]         dp_c,
  output logic                     dp_in_valid,
  input  logic [RES_W-1:0]         dp_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RES_W-1:0]         rsp_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [31:0]              stat_grants,
  output logic [31:0]              stat_stalls
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + DP_LATENCY + 2) + 1;

  sched_state_e state, state_nxt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    win_idx;
  logic [SEL_W-1:0]   win_a;
  logic [OPD_W-1:0]   win_b;
  logic [OPD_W-1:0]   win_c;
  logic               xfer;
  logic               credit;
  logic               push;
  logic               pop;

  logic [ID_W-1:0]       id_p0;
  logic [DP_LATENCY-1:0] vld_p1;
  logic [ID_W-1:0]       id_p1 [DP_LATENCY];

  logic [AW:0]        fifo_count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ID_W-1:0]    fifo_id   [FIFO_DEPTH];
  logic [RES_W-1:0]   fifo_data [FIFO_DEPTH];

  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   outstanding;

  ex3_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (xfer),
    .grant     (arb_grant),
    .grant_idx (win_idx)
  );

  always_comb begin
    inflight = CNT_W'(dp_in_valid);
    for (int i = 0; i < DP_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_p1[i]);
    end
  end

  assign rsp_valid   = (fifo_count != '0);
  assign pop         = rsp_valid & rsp_ready;
  assign push        = vld_p1[DP_LATENCY-1];
  // A slot is reserved for every operation from issue until its response is popped.
  assign outstanding = CNT_W'(fifo_count) + inflight - CNT_W'(pop);
  assign credit      = (outstanding < CNT_W'(FIFO_DEPTH));
  assign req_ready   = (state == ST_RUN && credit && !reset) ? arb_grant : '0;
  assign xfer        = |(req_valid & req_ready);

  always_comb begin
    win_a = '0;
    win_b = '0;
    win_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_a = req_a[i*SEL_W +: SEL_W];
        win_b = req_b[i*OPD_W +: OPD_W];
        win_c = req_c[i*OPD_W +: OPD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0 && fifo_count == '0) state_nxt = ST_DONE;
      ST_DONE: begin
        flush_done = 1'b1;
        state_nxt  = ST_RUN;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Issue stage (p0): operands presented to the datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_in_valid <= 1'b0;
      dp_a        <= '0;
      dp_b        <= '0;
      dp_c        <= '0;
      id_p0       <= '0;
    end else begin
      dp_in_valid <= xfer;
      if (xfer) begin
        dp_a  <= win_a;
        dp_b  <= win_b;
        dp_c  <= win_c;
        id_p0 <= win_idx;
      end
    end
  end

  // Latency line (p1): tracks requester IDs while the datapath computes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= '0;
      for (int i = 0; i < DP_LATENCY; i++) id_p1[i] <= '0;
    end else begin
      vld_p1[0] <= dp_in_valid;
      id_p1[0]  <= id_p0;
      for (int i = 1; i < DP_LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
        id_p1[i]  <= id_p1[i-1];
      end
    end
  end

  // Response FIFO: storage is not cleared; outputs are masked while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= id_p1[DP_LATENCY-1];
      fifo_data[wr_ptr] <= dp_out;
    end
  end

  assign rsp_id   = rsp_valid ? fifo_id[rd_ptr]   : '0;
  assign rsp_data = rsp_valid ? fifo_data[rd_ptr] : '0;

`ifdef EX3_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer)                stat_grants <= sat_inc(stat_grants);
      if (|req_valid && !xfer) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_ex3_scheduler.sv
// Bench for ex3_scheduler: queue-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ex3_scheduler;

  localparam int N = 4;
  localparam int L = 1;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*4-1:0]  req_a;
  logic [N*16-1:0] req_b;
  logic [N*16-1:0] req_c;
  logic [3:0]      dp_a;
  logic [15:0]     dp_b;
  logic [15:0]     dp_c;
  logic            dp_in_valid;
  logic [15:0]     dp_out = 16'h0;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;
  logic            flush;
  logic            flush_done;
  logic [31:0]     stat_grants;
  logic [31:0]     stat_stalls;

  ex3_scheduler #(.NUM_REQ(N), .DP_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_c       (req_c),
    .dp_a        (dp_a),
    .dp_b        (dp_b),
    .dp_c        (dp_c),
    .dp_in_valid (dp_in_valid),
    .dp_out      (dp_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: one register stage computing b^c
  always @(posedge clk) dp_out <= dp_b ^ dp_c;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } rsp_t;

  rsp_t        m_q[$];
  rsp_t        m_new;
  int          m_ptr, m_mode, m_cyc, m_grants, m_stalls, m_win, m_outst;
  bit          m_rv, m_pop, m_prev_x;
  logic [3:0]  m_pa;
  logic [15:0] m_pb, m_pc;
  logic [N-1:0] m_rdy;
  logic [63:0] m_tmp;

  task automatic model_reset();
    m_q.delete();
    m_ptr    = N - 1;
    m_mode   = 0;
    m_cyc    = 0;
    m_grants = 0;
    m_stalls = 0;
    m_prev_x = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      m_outst = m_q.size();
      m_rv    = (m_outst > 0) && (m_q[0].due <= m_cyc);
      m_pop   = m_rv && rsp_ready;
      m_win   = -1;
      if (m_mode == 0 && (m_outst - int'(m_pop)) < D) begin
        for (int i = 1; i <= N; i++) begin
          if (m_win < 0 && req_valid[(m_ptr + i) % N]) m_win = (m_ptr + i) % N;
        end
      end
      m_rdy = (m_win >= 0) ? (N'(1) << m_win) : '0;

      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
        check("rsp_id", 32'(rsp_id), m_q[0].id);
        check("rsp_data", 32'(rsp_data), 32'(m_q[0].data));
      end
      check("dp_in_valid", 32'(dp_in_valid), 32'(m_prev_x));
      if (m_prev_x) begin
        check("dp_a", 32'(dp_a), 32'(m_pa));
        check("dp_b", 32'(dp_b), 32'(m_pb));
        check("dp_c", 32'(dp_c), 32'(m_pc));
      end
      check("flush_done", 32'(flush_done), 32'(m_mode == 2));
`ifdef EX3_SCHED_STATS_EN
      check("stat_grants", stat_grants, m_grants);
      check("stat_stalls", stat_stalls, m_stalls);
`else
      check("stat_grants", stat_grants, 32'd0);
      check("stat_stalls", stat_stalls, 32'd0);
`endif

      if (m_pop) void'(m_q.pop_front());
      m_prev_x = (m_win >= 0);
      if (m_win >= 0) begin
        m_tmp = 64'(req_a >> (m_win * 4));
        m_pa  = m_tmp[3:0];
        m_tmp = req_b >> (m_win * 16);
        m_pb  = m_tmp[15:0];
        m_tmp = req_c >> (m_win * 16);
        m_pc  = m_tmp[15:0];
        m_new.id   = m_win;
        m_new.data = m_pb ^ m_pc;
        m_new.due  = m_cyc + 2 + L;
        m_q.push_back(m_new);
        m_ptr = m_win;
        m_grants++;
      end else if (|req_valid) begin
        m_stalls++;
      end
      case (m_mode)
        0: if (flush) m_mode = 1;
        1: if (m_outst == 0) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_ops(input int i, input logic [3:0] a, input logic [15:0] b, input logic [15:0] c);
    req_a[i*4 +: 4]   = a;
    req_b[i*16 +: 16] = b;
    req_c[i*16 +: 16] = c;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    for (int i = 0; i < N; i++) set_ops(i, 4'(i + 1), 16'hA000 | 16'(i), 16'h0F0F);

    // Reset values with requests pending
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_dp_in_valid", 32'(dp_in_valid), 32'h0);
    check("rst_dp_b", 32'(dp_b), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_flush_done", 32'(flush_done), 32'h0);
    check("rst_stat_grants", stat_grants, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request from requester 2
    set_ops(2, 4'h5, 16'h1234, 16'h00FF);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_grant", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("single_dp_valid", 32'(dp_in_valid), 32'h1);
    check("single_dp_a", 32'(dp_a), 32'h5);
    check("single_dp_b", 32'(dp_b), 32'h1234);
    check("single_dp_c", 32'(dp_c), 32'h00FF);
    next_cycle();
    @(negedge clk);
    check("single_rsp_early", 32'(rsp_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_rsp_data", 32'(rsp_data), 32'h12CB);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("single_no_extra", 32'(rsp_valid), 32'h0);
    end
    set_ops(2, 4'h3, 16'hA002, 16'h0F0F);
    next_cycle();

    // Round-robin with all requesters valid
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1) << (i % 4));
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
`ifdef EX3_SCHED_STATS_EN
    check("rr_stat_grants", stat_grants, 32'd8);
`else
    check("rr_stat_grants", stat_grants, 32'd0);
`endif
    check("rr_stat_stalls", stat_stalls, 32'd0);
    next_cycle();
    idle(5);

    // Backpressure: exactly FIFO_DEPTH transfers, then stall
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_grant", 32'(req_ready), (i < 4) ? (32'(1) << i) : 32'h0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_resume", 32'(req_ready), 32'h1);
    check("bp_rsp_id0", 32'(rsp_id), 32'h0);
    check("bp_rsp_data0", 32'(rsp_data), 32'hAF0F);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("bp_rsp_id1", 32'(rsp_id), 32'h1);
    check("bp_rsp_data1", 32'(rsp_data), 32'hAF0E);
    next_cycle();
    @(negedge clk);
    check("bp_rsp_id2", 32'(rsp_id), 32'h2);
    next_cycle();
    @(negedge clk);
    check("bp_rsp_id3", 32'(rsp_id), 32'h3);
    check("bp_rsp_data3", 32'(rsp_data), 32'hAF0C);
    next_cycle();
    @(negedge clk);
    check("bp_rsp_id4", 32'(rsp_id), 32'h0);
    next_cycle();
    idle(4);

    // Flush with operations in flight; grant in the flush cycle still completes
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    check("fl_grant0", 32'(req_ready), 32'h1);
    next_cycle();
    @(negedge clk);
    check("fl_grant1", 32'(req_ready), 32'h2);
    next_cycle();
    flush     = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("fl_grant_same_cycle", 32'(req_ready), 32'h4);
    next_cycle();
    flush     = 1'b0;
    req_valid = 4'b1111;
    for (int c = 3; c <= 7; c++) begin
      flush = (c == 4 || c == 7);
      @(negedge clk);
      check("fl_drain_no_grant", 32'(req_ready), 32'h0);
      check("fl_done_pulse", 32'(flush_done), (c == 7) ? 32'h1 : 32'h0);
      if (c <= 5) check("fl_rsp_id", 32'(rsp_id), 32'(c - 3));
      next_cycle();
    end
    flush = 1'b0;
    @(negedge clk);
    check("fl_resume", 32'(req_ready), 32'h8);
    check("fl_done_once", 32'(flush_done), 32'h0);
    next_cycle();
    idle(5);

    // Asynchronous reset one cycle after a transfer
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("rm_grant", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 4'b1111;
    check("rm_dp_valid_pre", 32'(dp_in_valid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("rm_dp_valid", 32'(dp_in_valid), 32'h0);
    check("rm_dp_a", 32'(dp_a), 32'h0);
    check("rm_dp_b", 32'(dp_b), 32'h0);
    check("rm_req_ready", 32'(req_ready), 32'h0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rm_stat_grants", stat_grants, 32'h0);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rm_no_rsp", 32'(rsp_valid), 32'h0);
      next_cycle();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    check("rm_first_winner", 32'(req_ready), 32'h1);
    next_cycle();
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
